bram_readback_checker: RTL
==========================

BRAM_READBACK_CHECKER -- requirements
Module: bram_readback_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each BRAM data port.
REQ-002 Parameter ADDR_WIDTH, default 10: width of each BRAM address port.
REQ-003 Parameter READ_LAT, default 1: BRAM read latency in clocks; legal range 1-4.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 start  input  1: request one full check pass; sampled only in IDLE.
REQ-007 addr_a, addr_b  output  ADDR_WIDTH: registered read addresses for ports A and B.
REQ-008 we_a, we_b  output  1: write enables; constant 0.
REQ-009 q_a, q_b  input  DATA_WIDTH: BRAM read data for ports A and B.
REQ-010 busy  output  1: high in every state except IDLE.
REQ-011 done  output  1: one-cycle pulse on the final cycle of a pass.
REQ-012 pass  output  1: result of the most recent completed pass; 1 = zero mismatches.
REQ-013 err_count  output  4: mismatches counted in the current or last pass; saturates at 15.
REQ-014 fail_addr  output  ADDR_WIDTH: address of the first mismatch in the current or last pass.

Function
REQ-015 Check table: NUM_PAIRS = 2 entries of {addr_a, addr_b, exp_a, exp_b}.
REQ-016 Entry 0 = {0, 1, 9, 11}; entry 1 = {510, 511, 32, 18}.
REQ-017 FSM states: IDLE, ISSUE, WAIT, COMPARE, NEXT, FINISH.
REQ-018 IDLE -> ISSUE when start = 1; pair index cleared, err_count cleared, fail_addr cleared, pass cleared.
REQ-019 ISSUE: addr_a/addr_b loaded from the current entry; held stable until leaving COMPARE.
REQ-020 WAIT: lasts exactly READ_LAT cycles, timed by a latency counter, then -> COMPARE.
REQ-021 COMPARE (1 cycle): q_a checked against exp_a and q_b against exp_b, full DATA_WIDTH equality.
REQ-022 Each mismatching port adds 1 to err_count (both mismatch = +2); saturates at 15, no wrap.
REQ-023 fail_addr captured only on the first mismatch of a pass; port A wins if both mismatch that cycle.
REQ-024 COMPARE -> NEXT; NEXT increments the pair index, -> ISSUE if index < NUM_PAIRS, else -> FINISH.
REQ-025 FINISH (1 cycle): done = 1, pass = (err_count == 0); -> IDLE.
REQ-026 Pass length with READ_LAT = 1: 1 + NUM_PAIRS*4 cycles from the start-accept edge to done (9 cycles).
REQ-027 start while busy is ignored; start held high in IDLE after FINISH begins a new pass.
REQ-028 pass, err_count and fail_addr hold their values in IDLE until the next accepted start.
REQ-029 addr_a/addr_b hold their last value in IDLE.

Reset
REQ-030 On reset = 1, state = IDLE immediately and all registered outputs = 0 (addr_a, addr_b, done, pass, err_count, fail_addr, busy).
REQ-031 Reset mid-pass aborts the pass; no done pulse is generated, and pass reads 0 after reset.
REQ-032 After reset deasserts, the first rising edge with start = 1 starts a pass.

Structure
REQ-033 State encoding, NUM_PAIRS and the check table constants belong in a shared package, bram_test_pkg, shared with the BRAM write sequencer.
REQ-034 Compare and error accumulation form one sub-module, bram_word_compare (inputs q, exp, valid; outputs mismatch).
REQ-035 All outputs are registered; there are no combinational paths from q_a/q_b to outputs.

Verification
REQ-036 Behavioural BRAM preloaded with 0:9, 1:11, 510:32, 511:18; start pulse -> done at cycle 9, pass = 1, err_count = 0.
REQ-037 Preload with addr 1 = 12 -> pass = 0, err_count = 1, fail_addr = 1.
REQ-038 Preload with addr 0 = 0, addr 1 = 0, addr 510 = 0 -> err_count = 3, fail_addr = 0.
REQ-039 Assert reset during WAIT of entry 1 -> all outputs 0 at once, no done pulse; a new start then completes normally with pass = 1.
REQ-040 Pulse start again during busy -> no effect and exactly one done pulse; then READ_LAT = 3 with a correct preload -> done at cycle 13, pass = 1.
REQ-041 we_a and we_b are checked to be 0 on every cycle in all scenarios.

Source files
------------

// File: rtl/bram_test_pkg.sv
// bram_test_pkg: FSM encoding, pair count and check table shared by the BRAM test blocks
package bram_test_pkg;
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMPARE, S_NEXT, S_FINISH} state_t;
   localparam int NUM_PAIRS = 2;
   typedef struct packed {
      logic [31:0] addr_a;
      logic [31:0] addr_b;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } pair_t;
   localparam pair_t CHECK_TABLE [NUM_PAIRS] = '{
      '{32'd0,   32'd1,   32'd9,  32'd11},
      '{32'd510, 32'd511, 32'd32, 32'd18}
   };
endpackage

// File: rtl/bram_word_compare.sv
// bram_word_compare: flags a read word that differs from its expected value; ports q/exp data, valid strobe, mismatch flag
module bram_word_compare #(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] q,
   input  logic [DATA_WIDTH-1:0] exp,
   input  logic                  valid,
   output logic                  mismatch
);
   assign mismatch = valid && (q != exp);
endmodule

// File: rtl/bram_readback_checker.sv
// bram_readback_checker: reads the check table pairs from a dual-port BRAM and reports pass/err_count/fail_addr; ports clk/reset/start in, addr/we to BRAM, q from BRAM, busy/done/pass/err_count/fail_addr status out
module bram_readback_checker
   import bram_test_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int READ_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] addr_a,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic                  we_a,
   output logic                  we_b,
   input  logic [DATA_WIDTH-1:0] q_a,
   input  logic [DATA_WIDTH-1:0] q_b,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [3:0]            err_count,
   output logic [ADDR_WIDTH-1:0] fail_addr
);
   localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
   state_t                state_q, state_d;
   logic [PW-1:0]         idx_q, idx_d;
   logic [1:0]            lat_q, lat_d;
   logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, fail_q, fail_d;
   logic [3:0]            err_q, err_d;
   logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic                  mm_a, mm_b;
   logic [4:0]            err_sum;
   bram_word_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp_a (
      .q        (q_a),
      .exp      (DATA_WIDTH'(CHECK_TABLE[idx_q].exp_a)),
      .valid    (state_q == S_COMPARE),
      .mismatch (mm_a)
   );
   bram_word_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp_b (
      .q        (q_b),
      .exp      (DATA_WIDTH'(CHECK_TABLE[idx_q].exp_b)),
      .valid    (state_q == S_COMPARE),
      .mismatch (mm_b)
   );
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      lat_d    = lat_q;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      err_d    = err_q;
      fail_d   = fail_q;
      pass_d   = pass_q;
      err_sum  = 5'(err_q) + 5'(mm_a) + 5'(mm_b);
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_ISSUE;
            idx_d   = '0;
            err_d   = '0;
            fail_d  = '0;
            pass_d  = 1'b0;
         end
         S_ISSUE: begin
            state_d  = S_WAIT;
            lat_d    = '0;
            addr_a_d = ADDR_WIDTH'(CHECK_TABLE[idx_q].addr_a);
            addr_b_d = ADDR_WIDTH'(CHECK_TABLE[idx_q].addr_b);
         end
         S_WAIT: begin
            lat_d   = lat_q + 2'd1;
            state_d = (lat_q == 2'(READ_LAT - 1)) ? S_COMPARE : S_WAIT;
         end
         S_COMPARE: begin
            state_d = S_NEXT;
            err_d   = (err_sum > 5'd15) ? 4'd15 : err_sum[3:0];
            // a zero count means nothing has failed yet this pass, so this is the first mismatch
            if (err_q == '0 && (mm_a || mm_b)) fail_d = mm_a ? addr_a_q : addr_b_q;
         end
         S_NEXT: begin
            idx_d   = idx_q + PW'(1);
            state_d = (idx_q == PW'(NUM_PAIRS - 1)) ? S_FINISH : S_ISSUE;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      // status flops are loaded from the next state so they line up with the state they describe
      busy_d = state_d != S_IDLE;
      done_d = state_d == S_FINISH;
      if (state_d == S_FINISH) pass_d = err_q == '0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         lat_q    <= '0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         err_q    <= '0;
         fail_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         lat_q    <= lat_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         err_q    <= err_d;
         fail_q   <= fail_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end
   assign addr_a    = addr_a_q;
   assign addr_b    = addr_b_q;
   assign we_a      = 1'b0;
   assign we_b      = 1'b0;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_addr = fail_q;
endmodule
